s2p_frame_multich: RTL

Parametrised successor to the stereo S2P converter for the MSDAP input path. It deserialises NUM_CH serial audio lanes in parallel, aligned to a frame-sync pulse. Completed word-sets are buffered in a small FIFO and handed to the filter core over a valid/ready handshake. It adds selectable bit order, mid-word frame-error detection and a sticky overflow flag.

---
 rtl/s2p_frame_multich.sv | 82 ++++++++
 1 files changed

// File: rtl/s2p_frame_multich.sv
// s2p_frame_multich: multi-lane frame-aligned serial-to-parallel converter with output FIFO
module s2p_frame_multich #(
  parameter int DATA_W     = 16,
  parameter int NUM_CH     = 2,
  parameter int MSB_FIRST  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               DCLK,
  input  logic                               Reset_n,
  input  logic                               Frame,
  input  logic [NUM_CH-1:0]                  SerialIn,
  input  logic                               clr_ovf,
  input  logic                               out_ready,
  output logic [NUM_CH*DATA_W-1:0]           ParallelOut,
  output logic                               out_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fill_level,
  output logic                               busy,
  output logic                               frame_err,
  output logic                               overflow
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t                            state;
  logic [CW-1:0]                     cnt;
  logic [NUM_CH-1:0][DATA_W-1:0]     sr, sr_nx;
  logic [NUM_CH*DATA_W-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]                     wp, rp;
  logic                              push, pop, full, wr_en;
  assign busy        = state == SHIFT;
  assign push        = state == SHIFT && !Frame && cnt == CW'(DATA_W - 1);
  assign out_valid   = fill_level != '0;
  assign pop         = out_valid && out_ready;
  assign full        = fill_level == FW'(FIFO_DEPTH);
  assign wr_en       = push && (!full || pop);
  assign ParallelOut = out_valid ? mem[rp] : '0;
  // each lane shifts in its current bit so the first bit of a word ends at its stated position
  always_comb begin
    sr_nx = sr;
    for (int k = 0; k < NUM_CH; k++)
      sr_nx[k] = MSB_FIRST != 0 ? {sr[k][DATA_W-2:0], SerialIn[k]} : {SerialIn[k], sr[k][DATA_W-1:1]};
  end
  // capture FSM: Frame always restarts a word, a mid-word Frame drops the partial and flags an error
  always_ff @(posedge DCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= Frame && state == SHIFT;
      if (Frame) begin
        state <= SHIFT;
        cnt   <= CW'(1);
        sr    <= sr_nx;
      end else if (state == SHIFT) begin
        state <= push ? IDLE : SHIFT;
        cnt   <= push ? '0 : cnt + CW'(1);
        sr    <= sr_nx;
      end
    end
  end
  // storage holds no reset; the output mux masks it whenever the FIFO is empty
  always_ff @(posedge DCLK) begin
    if (wr_en) mem[wp] <= sr_nx;
  end
  // pointers, occupancy and sticky overflow; a drop only happens when full with no pop in the same edge
  always_ff @(posedge DCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      wp         <= '0;
      rp         <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
    end else begin
      wp         <= wr_en ? wp + AW'(1) : wp;
      rp         <= pop ? rp + AW'(1) : rp;
      fill_level <= fill_level + FW'(wr_en) - FW'(pop);
      overflow   <= (push && full && !pop) ? 1'b1 : clr_ovf ? 1'b0 : overflow;
    end
  end
endmodule
